// File: rtl/jpeg_rle_ctrl_pkg.sv
// jpeg_rle_ctrl_pkg: shared JPEG block framing constants and sequencer state encoding
package jpeg_rle_ctrl_pkg;
    localparam int BLK_SAMPLES = 64;
    localparam int COEF_W = 12;
    localparam int IDX_W = $clog2(BLK_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SAMPLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;
endpackage

// File: rtl/jpeg_credit_cnt.sv
// jpeg_credit_cnt: credit up/down counter, one decrement and two increments per cycle
module jpeg_credit_cnt #(
    parameter int MAX = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec,
    input  logic         inc_a,
    input  logic         inc_b,
    output logic [W-1:0] cnt
);
    localparam logic [W+1:0] MAXV = MAX[W+1:0];
    logic [W+1:0] nxt;
    always_comb nxt = {2'b00, cnt} + {{(W+1){1'b0}}, inc_a} + {{(W+1){1'b0}}, inc_b} - {{(W+1){1'b0}}, dec};
    always_ff @(posedge clk) begin
        if (rst) cnt <= MAXV[W-1:0];
        else cnt <= nxt[W-1:0];
    end
    // an underflow wraps to a huge value, so this one bound also catches it
    always_ff @(posedge clk) begin
        if (!rst) assert (nxt <= MAXV);
    end
endmodule

// File: rtl/jpeg_rle_ctrl.sv
// jpeg_rle_ctrl: frames zig-zag coefficients into 64-sample blocks for the RLE stage,
// zero-padding short blocks and throttling issue against downstream FIFO credits
module jpeg_rle_ctrl
    import jpeg_rle_ctrl_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW = 4,
    parameter int BCW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [COEF_W-1:0] s_data,
    input  logic              s_sof,
    output logic              rle_ena,
    output logic              rle_go,
    output logic [COEF_W-1:0] rle_din,
    input  logic              rle_den,
    input  logic              cr_ret,
    output logic              busy,
    output logic              blk_done,
    output logic [BCW-1:0]    blk_cnt,
    output logic              err_sof,
    output logic              err_nosof,
    output logic [CW-1:0]     credits
);
    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             has_cr, issue, last, pend, sof_n, nosof_n;

    assign has_cr = credits != '0;
    assign busy = state != IDLE;
    assign rle_ena = issue;
    assign rle_din = state == PAD ? '0 : s_data;
    assign last = issue & (idx == LAST_IDX);

    always_comb begin
        s_ready = 1'b0;
        issue = 1'b0;
        rle_go = 1'b0;
        sof_n = 1'b0;
        nosof_n = 1'b0;
        case (state)
            IDLE: begin
                s_ready = has_cr | !s_sof;
                issue = s_valid & s_sof & has_cr;
                rle_go = s_valid & s_sof & has_cr;
                nosof_n = s_valid & !s_sof;
            end
            RUN: begin
                s_ready = has_cr & !s_sof;
                issue = s_valid & !s_sof & has_cr;
                sof_n = s_valid & s_sof;
            end
            PAD: issue = has_cr;
            default: ;
        endcase
        idx_n = last ? '0 : issue ? idx + IDX_W'(1) : idx;
        // the mid-block sof stays upstream and is picked up again from IDLE
        state_n = last ? IDLE
                : (state == IDLE && issue) ? RUN
                : sof_n ? PAD
                : (state == RUN || state == PAD) ? state : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            pend <= 1'b0;
            blk_cnt <= '0;
            blk_done <= 1'b0;
            err_sof <= 1'b0;
            err_nosof <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            pend <= issue;
            blk_cnt <= blk_cnt + BCW'(last);
            blk_done <= last;
            err_sof <= sof_n;
            err_nosof <= nosof_n;
        end
    end

    // an issue whose RLE cycle produced no token hands its credit straight back
    jpeg_credit_cnt #(.MAX(CREDITS), .W(CW)) u_cr (
        .clk   (clk),
        .rst   (rst),
        .dec   (issue),
        .inc_a (cr_ret),
        .inc_b (pend & !rle_den),
        .cnt   (credits)
    );
endmodule

// File: tb/tb_jpeg_rle_ctrl.sv
// tb_jpeg_rle_ctrl: directed bench for the RLE sequencer (CREDITS=4 main unit with a
// token/FIFO model, CREDITS=2 unit with hand-driven rle_den/cr_ret)
module tb_jpeg_rle_ctrl;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic s_valid = 0, s_sof = 0, s_ready, rle_ena, rle_go, rle_den, cr_ret;
    logic busy, blk_done, err_sof, err_nosof;
    logic [11:0] s_data = 0, rle_din;
    logic [15:0] blk_cnt;
    logic [3:0] credits;

    logic s2_valid = 0, s2_sof = 0, s2_ready, ena2, go2, den2 = 0, cr2 = 0;
    logic busy2, done2, esof2, enosof2;
    logic [11:0] s2_data = 0, din2;
    logic [15:0] cnt2;
    logic [3:0] credits2;

    jpeg_rle_ctrl #(.CREDITS(4), .CW(4), .BCW(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .rle_ena(rle_ena), .rle_go(rle_go), .rle_din(rle_din),
        .rle_den(rle_den), .cr_ret(cr_ret), .busy(busy), .blk_done(blk_done),
        .blk_cnt(blk_cnt), .err_sof(err_sof), .err_nosof(err_nosof), .credits(credits)
    );

    jpeg_rle_ctrl #(.CREDITS(2), .CW(4), .BCW(16)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
        .s_sof(s2_sof), .rle_ena(ena2), .rle_go(go2), .rle_din(din2),
        .rle_den(den2), .cr_ret(cr2), .busy(busy2), .blk_done(done2),
        .blk_cnt(cnt2), .err_sof(esof2), .err_nosof(enosof2), .credits(credits2)
    );

    // downstream model: a nonzero sample yields one token next cycle; FIFO pops when allowed
    logic prev_tok;
    int occ;
    logic auto_pop = 1;
    assign rle_den = prev_tok;
    assign cr_ret = auto_pop && occ != 0;
    always @(posedge clk) begin
        if (rst) begin
            prev_tok <= 0;
            occ <= 0;
        end else begin
            prev_tok <= rle_ena && rle_din != 0;
            occ <= occ + int'(rle_den) - int'(cr_ret);
        end
    end

    int pass_n = 0, total = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic v, sof;
        logic [11:0] d;
        logic rdy, ena, go, busy, nosof;
        logic [3:0] cr;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_ena, n_go, bad, got, n_pad;
        tbl[0]  = '{0, 0, 12'h000, 1, 0, 0, 0, 0, 4};
        tbl[1]  = '{1, 0, 12'h005, 1, 0, 0, 0, 0, 4};
        tbl[2]  = '{1, 0, 12'h007, 1, 0, 0, 0, 1, 4};
        tbl[3]  = '{0, 0, 12'h000, 1, 0, 0, 0, 1, 4};
        tbl[4]  = '{0, 0, 12'h000, 1, 0, 0, 0, 0, 4};
        tbl[5]  = '{1, 1, 12'h064, 1, 1, 1, 0, 0, 4};
        tbl[6]  = '{1, 0, 12'hFFD, 1, 1, 0, 1, 0, 3};
        tbl[7]  = '{0, 0, 12'h000, 1, 0, 0, 1, 0, 2};
        tbl[8]  = '{0, 0, 12'h000, 1, 0, 0, 1, 0, 3};
        tbl[9]  = '{0, 0, 12'h000, 1, 0, 0, 1, 0, 4};
        tbl[10] = '{1, 0, 12'h000, 1, 1, 0, 1, 0, 4};
        tbl[11] = '{0, 0, 12'h000, 1, 0, 0, 1, 0, 3};
        tbl[12] = '{0, 0, 12'h000, 1, 0, 0, 1, 0, 4};

        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_credits", 32'(credits), 4);
        chk("reset_blk_cnt", 32'(blk_cnt), 0);
        chk("reset_ready", 32'(s_ready), 1);
        chk("reset_credits2", 32'(credits2), 2);

        // nosof drops in IDLE, block start, token vs no-token credit return
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            s_valid = tbl[i].v;
            s_sof = tbl[i].sof;
            s_data = tbl[i].d;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_ena", i), 32'(rle_ena), 32'(tbl[i].ena));
            chk($sformatf("vec%0d_go", i), 32'(rle_go), 32'(tbl[i].go));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_nosof", i), 32'(err_nosof), 32'(tbl[i].nosof));
            chk($sformatf("vec%0d_credits", i), 32'(credits), 32'(tbl[i].cr));
            if (tbl[i].ena) chk($sformatf("vec%0d_din", i), 32'(rle_din), 32'(tbl[i].d));
        end

        // finish the first block (samples 3..63)
        n_ena = 0; n_go = 0;
        for (int i = 3; i < 64; i++) begin
            @(negedge clk);
            s_valid = 1; s_sof = 0; s_data = 12'(i + 1);
            #1;
            n_ena += int'(rle_ena);
            n_go += int'(rle_go);
        end
        chk("blk1_ena_count", n_ena, 61);
        chk("blk1_go_count", n_go, 0);
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("blk1_done", 32'(blk_done), 1);
        chk("blk1_cnt", 32'(blk_cnt), 1);
        chk("blk1_idle", 32'(busy), 0);
        chk("blk1_no_err_sof", 32'(err_sof), 0);
        @(negedge clk);
        #1;
        chk("blk1_done_pulse", 32'(blk_done), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("blk1_credits_back", 32'(credits), 4);

        // two back-to-back blocks with s_valid held high
        n_ena = 0; n_go = 0; bad = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            s_valid = 1; s_sof = (i % 64 == 0); s_data = 12'(12'h100 + i);
            #1;
            n_ena += int'(rle_ena);
            n_go += int'(rle_go);
            if (rle_go != (i % 64 == 0) || rle_din != s_data) bad++;
            if (i == 64) chk("b2b_done_at_64", 32'(blk_done), 1);
        end
        chk("b2b_ena_count", n_ena, 128);
        chk("b2b_go_count", n_go, 2);
        chk("b2b_go_pos_din", bad, 0);
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("b2b_blk_cnt", 32'(blk_cnt), 3);
        repeat (4) @(negedge clk);

        // sof arriving at idx 10 forces zero padding
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_valid = 1; s_sof = (i == 0); s_data = 12'(12'h200 + i);
        end
        @(negedge clk);
        s_sof = 1; s_data = 12'h7AB;
        #1;
        chk("midsof_ready", 32'(s_ready), 0);
        chk("midsof_ena", 32'(rle_ena), 0);
        @(negedge clk);
        #1;
        chk("midsof_err_sof", 32'(err_sof), 1);
        chk("midsof_busy", 32'(busy), 1);
        n_pad = 0; bad = 0; got = 0;
        for (int k = 0; k < 100; k++) begin
            if (blk_done) begin
                got = 1;
                break;
            end
            n_pad += int'(rle_ena);
            if (s_ready || (rle_ena && rle_din != 0)) bad++;
            @(negedge clk);
            #1;
        end
        chk("pad_done_seen", got, 1);
        chk("pad_count", n_pad, 54);
        chk("pad_zero_no_ready", bad, 0);
        chk("pad_sof_ena", 32'(rle_ena), 1);
        chk("pad_sof_go", 32'(rle_go), 1);
        chk("pad_sof_din", 32'(rle_din), 12'h7AB);
        chk("pad_blk_cnt", 32'(blk_cnt), 4);

        // reset at idx 30, then a clean block
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            s_sof = 0; s_data = 12'(12'h300 + i);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; s_valid = 0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_credits", 32'(credits), 4);
        chk("rst_mid_blk_cnt", 32'(blk_cnt), 0);
        n_ena = 0; n_go = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            s_valid = 1; s_sof = (i == 0); s_data = 12'(12'h400 + i);
            #1;
            n_ena += int'(rle_ena);
            n_go += int'(rle_go);
        end
        @(negedge clk);
        s_valid = 0; s_sof = 0;
        #1;
        chk("rst_blk_ena_count", n_ena, 64);
        chk("rst_blk_go_count", n_go, 1);
        chk("rst_blk_done", 32'(blk_done), 1);
        chk("rst_blk_cnt", 32'(blk_cnt), 1);

        // CREDITS=2 unit, nonzero data, no returns
        @(negedge clk);
        s2_valid = 1; s2_sof = 1; s2_data = 12'h011; den2 = 0;
        #1;
        chk("c2_issue0_ena", 32'(ena2), 1);
        chk("c2_issue0_go", 32'(go2), 1);
        @(negedge clk);
        s2_sof = 0; s2_data = 12'h022; den2 = 1;
        #1;
        chk("c2_issue1_ena", 32'(ena2), 1);
        @(negedge clk);
        s2_data = 12'h033;
        #1;
        chk("c2_stall_ready", 32'(s2_ready), 0);
        chk("c2_stall_ena", 32'(ena2), 0);
        chk("c2_stall_credits", 32'(credits2), 0);
        @(negedge clk);
        #1;
        chk("c2_hold_credits", 32'(credits2), 0);
        @(negedge clk);
        cr2 = 1;
        #1;
        chk("c2_ret_cycle_ena", 32'(ena2), 0);
        @(negedge clk);
        cr2 = 0; den2 = 0;
        #1;
        chk("c2_one_more_ena", 32'(ena2), 1);
        chk("c2_one_more_credits", 32'(credits2), 1);
        n_ena = 0;
        repeat (4) begin
            @(negedge clk);
            den2 = 1;
            #1;
            n_ena += int'(ena2);
        end
        chk("c2_no_extra_ena", n_ena, 0);
        chk("c2_empty_again", 32'(credits2), 0);
        @(negedge clk);
        s2_valid = 0; cr2 = 1;
        @(negedge clk);
        @(negedge clk);
        cr2 = 0;
        #1;
        chk("c2_refilled", 32'(credits2), 2);
        // zero coefficients yield no tokens, so credits cycle back without stalling
        den2 = 0; n_ena = 0;
        for (int i = 3; i < 64; i++) begin
            @(negedge clk);
            s2_valid = 1; s2_data = 12'h000;
            #1;
            n_ena += int'(ena2);
        end
        chk("c2_zero_ena_count", n_ena, 61);
        @(negedge clk);
        s2_valid = 0;
        #1;
        chk("c2_blk_done", 32'(done2), 1);
        chk("c2_blk_cnt", 32'(cnt2), 1);
        chk("c2_no_err", 32'(esof2 | enosof2), 0);

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule
